// File: rtl/vending_pkg.sv
// Shared vending-machine types: change codes, coin values, state enums and change decode.
// Pure definitions; no timing or flow-control behaviour of its own.
package vending_pkg;

  localparam logic [2:0] CHG_NONE = 3'b000;
  localparam logic [2:0] CHG_5    = 3'b001;
  localparam logic [2:0] CHG_10   = 3'b010;
  localparam logic [2:0] CHG_15   = 3'b011;
  localparam logic [2:0] CHG_20   = 3'b100;

  localparam logic [4:0] NICKEL_VAL  = 5'd5;
  localparam logic [4:0] DIME_VAL    = 5'd10;
  localparam logic [4:0] QUARTER_VAL = 5'd25;

  // Upstream controller state; kept apart from the dispenser enum.
  typedef enum logic [1:0] {
    CTRL_IDLE, CTRL_FIVE, CTRL_TEN, CTRL_FIFTEEN
  } ctrl_state_t;

  typedef enum logic [2:0] {
    DSP_IDLE, DSP_SELECT, DSP_EJECT, DSP_GAP, DSP_DONE, DSP_FAULT
  } disp_state_t;

  typedef enum logic [1:0] {
    COIN_NONE, COIN_DIME, COIN_NICKEL
  } coin_t;

  // Reserved codes 101-111 decode to zero cents.
  function automatic logic [4:0] change_cents(input logic [2:0] code);
    logic [4:0] cents;
    case (code)
      CHG_5:   cents = 5'd5;
      CHG_10:  cents = 5'd10;
      CHG_15:  cents = 5'd15;
      CHG_20:  cents = 5'd20;
      default: cents = 5'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/eject_timeout.sv
// Watchdog for an outstanding eject request: counts enabled cycles, flags the last allowed one.
// Expired is combinational from the count; counting stops once expired until cleared.
module eject_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/change_dispenser.sv
// Turns a soda/change strobe into dime-first coin ejections over a 4-phase req/ack handshake.
// Eject request rises two cycles after soda; soda arriving while busy is dropped and flagged.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int STOCK_W        = 8,
  parameter int DIME_FULL      = 50,
  parameter int NICKEL_FULL    = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soda,
  input  logic [2:0]         change,
  input  logic               eject_ack,
  input  logic               refill,
  input  logic               clear_fault,
  output logic               eject_dime,
  output logic               eject_nickel,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic               req_drop,
  output logic [STOCK_W-1:0] dime_cnt,
  output logic [STOCK_W-1:0] nickel_cnt
);

  localparam logic [STOCK_W-1:0] DIME_INIT   = STOCK_W'(DIME_FULL);
  localparam logic [STOCK_W-1:0] NICKEL_INIT = STOCK_W'(NICKEL_FULL);
  localparam logic [STOCK_W-1:0] ONE         = STOCK_W'(1);

  disp_state_t state, state_nxt;
  coin_t       coin, sel_coin;
  logic [4:0]  remaining;
  logic [4:0]  soda_cents;
  logic        expired;

  assign soda_cents = change_cents(change);

  eject_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == DSP_SELECT),
    .enable  (state == DSP_EJECT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DSP_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_coin  = COIN_NONE;
    case (state)
      DSP_IDLE: begin
        if (soda && soda_cents != 5'd0) state_nxt = DSP_SELECT;
      end
      DSP_SELECT: begin
        if (remaining == 5'd0) begin
          state_nxt = DSP_DONE;
        end else if (remaining >= DIME_VAL && dime_cnt != '0) begin
          sel_coin  = COIN_DIME;
          state_nxt = DSP_EJECT;
        end else if (nickel_cnt != '0) begin
          sel_coin  = COIN_NICKEL;
          state_nxt = DSP_EJECT;
        end else begin
          state_nxt = DSP_FAULT;
        end
      end
      // An ack on the expiry cycle still counts as a delivered coin.
      DSP_EJECT: begin
        if (eject_ack)    state_nxt = DSP_GAP;
        else if (expired) state_nxt = DSP_FAULT;
      end
      DSP_GAP: begin
        if (!eject_ack) state_nxt = DSP_SELECT;
      end
      DSP_DONE:  state_nxt = DSP_IDLE;
      DSP_FAULT: begin
        if (clear_fault) state_nxt = DSP_IDLE;
      end
      default:   state_nxt = DSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining  <= 5'd0;
      coin       <= COIN_NONE;
      dime_cnt   <= DIME_INIT;
      nickel_cnt <= NICKEL_INIT;
      req_drop   <= 1'b0;
    end else begin
      req_drop <= soda && (state != DSP_IDLE);
      case (state)
        DSP_IDLE: begin
          if (soda) begin
            if (soda_cents != 5'd0) remaining <= soda_cents;
          end else if (refill) begin
            dime_cnt   <= DIME_INIT;
            nickel_cnt <= NICKEL_INIT;
          end
        end
        DSP_SELECT: coin <= sel_coin;
        DSP_EJECT: begin
          if (eject_ack) begin
            if (coin == COIN_DIME) begin
              dime_cnt  <= dime_cnt - ONE;
              remaining <= remaining - DIME_VAL;
            end else if (coin == COIN_NICKEL) begin
              nickel_cnt <= nickel_cnt - ONE;
              remaining  <= remaining - NICKEL_VAL;
            end
            coin <= COIN_NONE;
          end
        end
        DSP_FAULT: begin
          if (clear_fault) begin
            remaining <= 5'd0;
            coin      <= COIN_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign eject_dime   = (state == DSP_EJECT) && (coin == COIN_DIME);
  assign eject_nickel = (state == DSP_EJECT) && (coin == COIN_NICKEL);
  assign busy         = (state != DSP_IDLE);
  assign done         = (state == DSP_DONE);
  assign fault        = (state == DSP_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table of whole transactions plus hand-written
// sequences for latency, dropped requests, timeout, stock exhaustion and mid-eject reset.
module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       soda;
  logic [2:0] change;
  logic       eject_ack;
  logic       refill;
  logic       clear_fault;
  logic       eject_dime;
  logic       eject_nickel;
  logic       busy;
  logic       done;
  logic       fault;
  logic       req_drop;
  logic [7:0] dime_cnt;
  logic [7:0] nickel_cnt;

  change_dispenser #(
    .STOCK_W(8), .DIME_FULL(50), .NICKEL_FULL(100), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soda(soda), .change(change), .eject_ack(eject_ack),
    .refill(refill), .clear_fault(clear_fault), .eject_dime(eject_dime),
    .eject_nickel(eject_nickel), .busy(busy), .done(done), .fault(fault),
    .req_drop(req_drop), .dime_cnt(dime_cnt), .nickel_cnt(nickel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Ejector model: acks on the 2nd cycle a request is seen, drops ack once request falls.
  bit         ack_en;
  int         rcnt;
  logic [7:0] coin_seq;
  int         coin_n;
  int         both_high;

  initial begin
    eject_ack = 1'b0;
    rcnt      = 0;
    both_high = 0;
    forever begin
      @(negedge clk);
      if (eject_dime && eject_nickel) both_high++;
      if (eject_ack) begin
        if (!eject_dime && !eject_nickel) eject_ack = 1'b0;
      end else if (ack_en && (eject_dime || eject_nickel)) begin
        rcnt++;
        if (rcnt == 2) begin
          coin_seq  = coin_seq | ((eject_dime ? 8'd2 : 8'd1) << (2 * coin_n));
          coin_n++;
          eject_ack = 1'b1;
          rcnt      = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  task automatic strobe(input bit s, input logic [2:0] code, input bit rf);
    coin_seq = 8'd0;
    coin_n   = 0;
    soda     = s;
    change   = code;
    refill   = rf;
    @(negedge clk);
    soda   = 1'b0;
    change = 3'd0;
    refill = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int n_done);
    bit seen  = 0;
    bit ended = 0;
    n_done = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) n_done++;
      if (busy) seen = 1;
      if (!busy && (seen || i >= 4)) begin
        ended = 1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_bound"}, int'(ended), 1);
  endtask

  task automatic run_txn(input string name, input bit s, input logic [2:0] code,
                         input bit rf, output int n_done);
    strobe(s, code, rf);
    wait_idle(name, n_done);
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit         s;
    logic [2:0] code;
    bit         rf;
    logic [7:0] seq;   // 2 bits per coin, first coin in LSBs: 2=dime, 1=nickel
    int         len;
    int         dc;
    int         nc;
    int         dn;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int nd;
    int n;
    bit ok;
    rst_n = 1'b0; soda = 1'b0; change = 3'd0; refill = 1'b0; clear_fault = 1'b0;
    ack_en = 1'b1; coin_seq = 8'd0; coin_n = 0;

    vecs[0] = '{1'b1, 3'b011, 1'b0, 8'd6,  2, 49, 99, 1};
    vecs[1] = '{1'b1, 3'b100, 1'b0, 8'd10, 2, 47, 99, 1};
    vecs[2] = '{1'b1, 3'b001, 1'b0, 8'd1,  1, 47, 98, 1};
    vecs[3] = '{1'b1, 3'b010, 1'b0, 8'd2,  1, 46, 98, 1};
    vecs[4] = '{1'b1, 3'b000, 1'b0, 8'd0,  0, 46, 98, 0};
    vecs[5] = '{1'b1, 3'b101, 1'b0, 8'd0,  0, 46, 98, 0};
    vecs[6] = '{1'b1, 3'b111, 1'b0, 8'd0,  0, 46, 98, 0};
    vecs[7] = '{1'b1, 3'b010, 1'b1, 8'd2,  1, 45, 98, 1};
    vecs[8] = '{1'b1, 3'b110, 1'b1, 8'd0,  0, 45, 98, 0};
    vecs[9] = '{1'b0, 3'b000, 1'b1, 8'd0,  0, 50, 100, 0};

    #12;
    chk("rst_outputs", int'({eject_dime, eject_nickel, busy, done, fault, req_drop}), 0);
    chk("rst_dime_cnt", int'(dime_cnt), 50);
    chk("rst_nickel_cnt", int'(nickel_cnt), 100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].s, vecs[i].code, vecs[i].rf, nd);
      chk($sformatf("v%0d_seq", i), int'(coin_seq), int'(vecs[i].seq));
      chk($sformatf("v%0d_len", i), coin_n, vecs[i].len);
      chk($sformatf("v%0d_dime_cnt", i), int'(dime_cnt), vecs[i].dc);
      chk($sformatf("v%0d_nickel_cnt", i), int'(nickel_cnt), vecs[i].nc);
      chk($sformatf("v%0d_done", i), nd, vecs[i].dn);
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // Request latency and a soda dropped while the sequence is in flight.
    strobe(1'b1, 3'b011, 1'b0);
    chk("lat_select_busy", int'(busy), 1);
    chk("lat_select_no_eject", int'(eject_dime), 0);
    @(negedge clk);
    chk("lat_eject_dime", int'(eject_dime), 1);
    chk("lat_eject_nickel", int'(eject_nickel), 0);
    soda = 1'b1; change = 3'b100;
    @(negedge clk);
    soda = 1'b0; change = 3'd0;
    chk("drop_pulse", int'(req_drop), 1);
    @(negedge clk);
    chk("drop_one_cycle", int'(req_drop), 0);
    wait_idle("drop", nd);
    chk("drop_seq", int'(coin_seq), 6);
    chk("drop_done", nd, 1);
    chk("drop_dime_cnt", int'(dime_cnt), 49);
    chk("drop_nickel_cnt", int'(nickel_cnt), 99);

    // Stuck mechanism: no ack ever arrives.
    ack_en = 1'b0;
    strobe(1'b1, 3'b010, 1'b0);
    n  = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (eject_dime) n++;
      if (fault) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("to_reached", int'(ok), 1);
    chk("to_req_cycles", n, 8);
    chk("to_eject_low", int'({eject_dime, eject_nickel}), 0);
    chk("to_busy", int'(busy), 1);
    chk("to_dime_cnt", int'(dime_cnt), 49);
    chk("to_nickel_cnt", int'(nickel_cnt), 99);
    pulse_clear();
    chk("to_clear_busy", int'(busy), 0);
    chk("to_clear_fault", int'(fault), 0);
    ack_en = 1'b1;

    // Run dimes down to one, then 20 cents must fall back to nickels.
    run_txn("refill1", 1'b0, 3'd0, 1'b1, nd);
    for (int i = 0; i < 49; i++) run_txn("dime_drain", 1'b1, 3'b010, 1'b0, nd);
    chk("drain_dime_cnt", int'(dime_cnt), 1);
    run_txn("low_dime", 1'b1, 3'b100, 1'b0, nd);
    chk("low_dime_seq", int'(coin_seq), 22);
    chk("low_dime_len", coin_n, 3);
    chk("low_dime_dime_cnt", int'(dime_cnt), 0);
    chk("low_dime_nickel_cnt", int'(nickel_cnt), 98);
    chk("low_dime_done", nd, 1);

    // Exhaust nickels: the next request has no coin to pay with.
    for (int i = 0; i < 98; i++) run_txn("nickel_drain", 1'b1, 3'b001, 1'b0, nd);
    chk("drain_nickel_cnt", int'(nickel_cnt), 0);
    strobe(1'b1, 3'b001, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (fault) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("empty_fault", int'(ok), 1);
    chk("empty_no_eject", coin_n, 0);
    chk("empty_busy", int'(busy), 1);
    pulse_clear();
    chk("empty_clear_busy", int'(busy), 0);
    chk("empty_clear_fault", int'(fault), 0);
    run_txn("refill2", 1'b0, 3'd0, 1'b1, nd);
    chk("refill2_dime_cnt", int'(dime_cnt), 50);
    chk("refill2_nickel_cnt", int'(nickel_cnt), 100);

    // Reset while a nickel request is outstanding.
    run_txn("pre_rst", 1'b1, 3'b010, 1'b0, nd);
    chk("pre_rst_dime_cnt", int'(dime_cnt), 49);
    ack_en = 1'b0;
    strobe(1'b1, 3'b001, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (eject_nickel) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_req_seen", int'(ok), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({eject_dime, eject_nickel, busy, done, fault, req_drop}), 0);
    chk("rst_mid_dime_cnt", int'(dime_cnt), 50);
    chk("rst_mid_nickel_cnt", int'(nickel_cnt), 100);
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    strobe(1'b1, 3'b101, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || done || eject_dime || eject_nickel) n++;
      @(negedge clk);
    end
    chk("post_rst_code5_idle", n, 0);
    chk("one_hot_ejects", both_high, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
